// File: rtl/l2_mem_arbiter_pkg.sv
// l2_arb_pkg: shared types and constants for the L2 cache-memory arbiter.
//   state_e   : arbiter FSM states (IDLE, ISSUE, WAIT_RD)
//   ADDR_W_DEF: default memory address width
//   LINE_W_DEF: default cacheline width
//   clog2()   : index width helper, never returns less than 1
package l2_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned LINE_W_DEF = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT_RD = 2'd2
   } state_e;

   // Width needed to index n items; a single item still gets one bit.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/l2_mem_arbiter_if.sv
// l2_mem_arbiter_if: cache-side and memory-side bus of the L2 memory arbiter.
//   Cache side : req_rden, req_wren, req_addr, req_wdata -> req_grant,
//                rsp_data, rsp_valid, rsp_err
//   Memory side: mem_addr, mem_wdata, mem_rden, mem_wren -> mem_rdata,
//                mem_rdata_valid
//   modport slave  : the arbiter
//   modport master : the caches + memory model driving the arbiter
interface l2_mem_arbiter_if #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = l2_arb_pkg::ADDR_W_DEF,
   parameter int unsigned LINE_W  = l2_arb_pkg::LINE_W_DEF
);
   logic [NUM_REQ-1:0]        req_rden;
   logic [NUM_REQ-1:0]        req_wren;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*LINE_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_grant;
   logic [LINE_W-1:0]         rsp_data;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [NUM_REQ-1:0]        rsp_err;
   logic [ADDR_W-1:0]         mem_addr;
   logic [LINE_W-1:0]         mem_wdata;
   logic                      mem_rden;
   logic                      mem_wren;
   logic [LINE_W-1:0]         mem_rdata;
   logic                      mem_rdata_valid;

   modport slave (
      input  req_rden, req_wren, req_addr, req_wdata, mem_rdata, mem_rdata_valid,
      output req_grant, rsp_data, rsp_valid, rsp_err,
             mem_addr, mem_wdata, mem_rden, mem_wren
   );

   modport master (
      output req_rden, req_wren, req_addr, req_wdata, mem_rdata, mem_rdata_valid,
      input  req_grant, rsp_data, rsp_valid, rsp_err,
             mem_addr, mem_wdata, mem_rden, mem_wren
   );

endinterface

// File: rtl/l2_mem_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   i_pending : request vector
//   i_ptr     : last granted index; search starts at i_ptr+1 and wraps
//   o_grant_c : one-hot winner
//   o_idx_c   : winner index
//   o_valid_c : any request pending
module rr_arbiter
   import l2_arb_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = clog2(N)
) (
   input  logic [N-1:0]     i_pending,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N-1:0]     o_grant_c,
   output logic [IDX_W-1:0] o_idx_c,
   output logic             o_valid_c
);

   // Walk N positions starting after the pointer; the pointer itself is last.
   always_comb begin
      logic [IDX_W-1:0] j;
      o_grant_c = '0;
      o_idx_c   = '0;
      o_valid_c = 1'b0;
      j         = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         j = IDX_W'((32'(i_ptr) + i) % N);
         if (!o_valid_c && i_pending[j]) begin
            o_valid_c    = 1'b1;
            o_grant_c[j] = 1'b1;
            o_idx_c      = j;
         end
      end
   end

endmodule

// File: rtl/l2_mem_arbiter.sv
// l2_mem_arbiter: shares one cache-memory port among NUM_REQ L2 caches.
//   clk, reset : clock, synchronous active-high reset
//   bus        : l2_mem_arbiter_if.slave (cache requests/responses + memory port)
// Writes and reads are granted round-robin, one at a time; at most one read
// is in flight and its fill data is steered to the requester that issued it.
// Optional build macro L2_ARB_TIMEOUT_EN adds a read watchdog of TIMEOUT
// cycles that reports expiry on rsp_err; without it rsp_err is tied to 0.
module l2_mem_arbiter
   import l2_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned LINE_W  = LINE_W_DEF,
   parameter int unsigned TIMEOUT = 64
) (
   input logic               clk,
   input logic               reset,
   l2_mem_arbiter_if.slave   bus
);

   localparam int unsigned IDX_W = clog2(NUM_REQ);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_owner;
   logic [NUM_REQ-1:0] r_grant;
   logic               r_mem_rden;
   logic               r_mem_wren;
   logic [ADDR_W-1:0]  r_mem_addr;
   logic [LINE_W-1:0]  r_mem_wdata;

   logic [NUM_REQ-1:0] w_pending;
   logic [NUM_REQ-1:0] w_win_oh;
   logic [IDX_W-1:0]   w_win_idx;
   logic               w_win_vld;
   logic               w_win_wr;
   logic               w_issue;
   logic               w_rd_done;
   logic               w_timeout;
   logic [NUM_REQ-1:0] w_owner_oh;
   logic [NUM_REQ-1:0] w_rsp_err;

   assign w_pending  = bus.req_rden | bus.req_wren;
   assign w_issue    = (r_state == IDLE) && w_win_vld;
   // A port raising both is served as a write first; its read stays pending.
   assign w_win_wr   = bus.req_wren[w_win_idx];
   assign w_rd_done  = (r_state == WAIT_RD) && bus.mem_rdata_valid;
   assign w_owner_oh = NUM_REQ'(1) << r_owner;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .i_pending (w_pending),
      .i_ptr     (r_ptr),
      .o_grant_c (w_win_oh),
      .o_idx_c   (w_win_idx),
      .o_valid_c (w_win_vld)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_win_vld) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = r_mem_rden ? WAIT_RD : IDLE;
         WAIT_RD: if (w_rd_done || w_timeout) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Grant/strobe pulses and the memory request are captured when leaving IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr       <= IDX_W'(NUM_REQ - 1);
         r_owner     <= '0;
         r_grant     <= '0;
         r_mem_rden  <= 1'b0;
         r_mem_wren  <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_grant    <= '0;
         r_mem_rden <= 1'b0;
         r_mem_wren <= 1'b0;
         if (w_issue) begin
            r_grant     <= w_win_oh;
            r_mem_wren  <= w_win_wr;
            r_mem_rden  <= !w_win_wr;
            r_mem_addr  <= bus.req_addr[32'(w_win_idx)*ADDR_W +: ADDR_W];
            r_mem_wdata <= bus.req_wdata[32'(w_win_idx)*LINE_W +: LINE_W];
            r_owner     <= w_win_idx;
            r_ptr       <= w_win_idx;
         end
      end
   end

`ifdef L2_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = clog2(TIMEOUT);

   logic [CNT_W-1:0]   r_wd_cnt;
   logic [NUM_REQ-1:0] r_rsp_err;

   // Watchdog counts cycles spent in WAIT_RD; zero on entry.
   always_ff @(posedge clk) begin
      if (reset || (r_state != WAIT_RD)) r_wd_cnt <= '0;
      else                               r_wd_cnt <= r_wd_cnt + CNT_W'(1);
   end

   assign w_timeout = (r_state == WAIT_RD) && !bus.mem_rdata_valid &&
                      (r_wd_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) r_rsp_err <= '0;
      else       r_rsp_err <= w_timeout ? w_owner_oh : '0;
   end

   assign w_rsp_err = r_rsp_err;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT != 0);
   assign w_timeout        = 1'b0;
   assign w_rsp_err        = '0;
`endif

   assign bus.req_grant = r_grant;
   assign bus.mem_rden  = r_mem_rden;
   assign bus.mem_wren  = r_mem_wren;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.rsp_err   = w_rsp_err;
   // Fill data is broadcast; only the owner's valid bit rises, and only in WAIT_RD.
   assign bus.rsp_data  = bus.mem_rdata;
   assign bus.rsp_valid = w_rd_done ? w_owner_oh : '0;

endmodule

// File: doc/l2_mem_arbiter.md
# l2_mem_arbiter

Shares one cache-memory port among `NUM_REQ` L2 cache instances. Each cache's eviction writes and fill reads are arbitrated round-robin onto the memory side. Fill data is steered back only to the requester that issued the read. The block sits between the L2 caches' cache-mem interfaces and the memory model/controller, and supports at most one memory read in flight.

## Interface
- `NUM_REQ`, 4: number of cache requesters (1..8).
- `ADDR_W`, 32: address width.
- `LINE_W`, 128: cacheline width.
- `TIMEOUT`, 64: read watchdog limit in cycles; used only with `L2_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req_rden`  in  NUM_REQ  per-port fill-read request, level, held until granted.
- `req_wren`  in  NUM_REQ  per-port eviction-write request, level, held until granted.
- `req_addr`  in  NUM_REQ*ADDR_W  flattened addresses; port k at `[k*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  NUM_REQ*LINE_W  flattened eviction lines.
- `req_grant`  out  NUM_REQ  one-hot, one-cycle grant pulse.
- `rsp_data`  out  LINE_W  fill data, broadcast.
- `rsp_valid`  out  NUM_REQ  one-hot fill-data-valid for the owner.
- `rsp_err`  out  NUM_REQ  one-hot watchdog-expiry pulse; constant 0 without the macro.
- `mem_addr`  out  ADDR_W  registered memory address.
- `mem_wdata`  out  LINE_W  registered write line.
- `mem_rden`  out  1  one-cycle read strobe.
- `mem_wren`  out  1  one-cycle write strobe.
- `mem_rdata`  in  LINE_W  memory read data.
- `mem_rdata_valid`  in  1  read-data-valid pulse; fixed memory latency, in order.

## Operation
- States:
  - IDLE: select a winner; if any request is pending, go to ISSUE.
  - ISSUE: one cycle with the strobe and grant active. A write returns to IDLE; a read goes to WAIT_RD.
  - WAIT_RD: hold until `mem_rdata_valid`, then go to IDLE.
- Round-robin: search starts at the port after the last granted port, wrapping from NUM_REQ-1 to 0. After reset the pointer is NUM_REQ-1, so port 0 has first priority. The pointer updates only when a grant is issued.
- A port is pending if `req_rden|req_wren`. If a port raises both, the write is served first and the read stays pending. That port then competes again under normal round-robin.
- `req_grant`, `mem_*` and the latched owner index are registered on the IDLE→ISSUE edge. `mem_addr`/`mem_wdata` hold their values until the next grant.
- The requester must drop the granted request bit on the clock edge where it samples `req_grant`=1.
- In WAIT_RD, `rsp_valid[owner] = mem_rdata_valid` and `rsp_data = mem_rdata`, both combinational pass-through.
- `mem_rdata_valid` outside WAIT_RD is ignored: no `rsp_valid`, no state change.
- Reset values: state IDLE, `req_grant`=0, `mem_rden`=0, `mem_wren`=0, `mem_addr`=0, `mem_wdata`=0, `rsp_valid`=0, `rsp_err`=0, pointer NUM_REQ-1.
- Reset mid-read abandons the transaction. A late valid pulse that arrives afterwards is ignored per the rule above.

## Timing
- Request seen in IDLE at cycle 0 → grant and strobe in cycle 1.
- Read data arrives in cycle 1+D for a memory delay D; `rsp_valid` is in the same cycle.
- Write throughput: one write per 2 cycles.
- Read occupancy: D+2 cycles including the IDLE cycle.
- Requests arriving during ISSUE/WAIT_RD wait; they are not lost and do not reorder the pointer.

## Configuration
- `L2_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT_RD and increments each cycle there.
  - When the counter reaches TIMEOUT-1 without valid: pulse `rsp_err[owner]` for one cycle, emit no `rsp_valid`, return to IDLE.
- Not defined: no counter; WAIT_RD waits indefinitely; `rsp_err` is tied to 0.

## Structure
- `l2_arb_pkg`: state enum (IDLE, ISSUE, WAIT_RD), default `ADDR_W`/`LINE_W` constants, and the index width function `clog2(NUM_REQ)`.
- Sub-module `rr_arbiter`: combinational round-robin pick. Takes a pending vector and a pointer; outputs a one-hot winner and its index.

## Test plan
- Single read, port 0, addr 0x6F76D100, memory D=5 → `mem_rden` in cycle 1, `rsp_valid`=4'b0001 in cycle 6 with `rsp_data`=`mem_rdata`, no other port sees valid.
- Ports 0–3 raise reads at once → grants in order 0,1,2,3, each granted only after the previous `rsp_valid`. A second identical burst repeats the order 0,1,2,3.
- Port 2 raises `wren`+`rden` with `req_wdata`=0xDEADBEEF → `mem_wren` first with that data, then `mem_rden` on a later grant, then `rsp_valid`=4'b0100.
- Stray `mem_rdata_valid` in IDLE → `rsp_valid` stays 0 and the state is unchanged. Reset asserted in WAIT_RD, followed by the late valid → all outputs are 0 and no response is issued.
- With `L2_ARB_TIMEOUT_EN`, TIMEOUT=8, and memory never answering port 1 → `rsp_err`=4'b0010 pulses 8 cycles after entering WAIT_RD, then a pending port 3 read is granted.
